// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of a shared combinational ALU.
// Each port owns a one-entry response buffer; results appear one cycle after the grant.
module alu_arbiter #(
  parameter int unsigned FAIR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  output logic        rsp0_valid,
  output logic        rsp1_valid,
  input  logic        rsp0_ready,
  input  logic        rsp1_ready,
  output logic [31:0] rsp0_result,
  output logic [31:0] rsp1_result,
  output logic        rsp0_zero,
  output logic        rsp1_zero,
  output logic        rsp0_err,
  output logic        rsp1_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  typedef enum logic {
    PTR_P0 = 1'b0,
    PTR_P1 = 1'b1
  } ptr_e;

  localparam logic [3:0] OP_LAST_LEGAL = 4'd9;

  ptr_e        r_ptr;
  logic        r_rsp0_valid;
  logic        r_rsp1_valid;
  logic [31:0] r_rsp0_result;
  logic [31:0] r_rsp1_result;
  logic        r_rsp0_zero;
  logic        r_rsp1_zero;
  logic        r_rsp0_err;
  logic        r_rsp1_err;

  logic        w_elig0;
  logic        w_elig1;
  logic        w_p0_first;
  logic        w_grant0;
  logic        w_grant1;
  logic        w_any_grant;
  logic [31:0] w_sel_a;
  logic [31:0] w_sel_b;
  logic [3:0]  w_sel_op;
  logic        w_sel_illegal;
  logic [31:0] w_ld_result;
  logic        w_ld_zero;

  // A port may issue when its buffer is empty or is being handed off this cycle.
  assign w_elig0    = req0_valid && (!r_rsp0_valid || rsp0_ready);
  assign w_elig1    = req1_valid && (!r_rsp1_valid || rsp1_ready);
  assign w_p0_first = (FAIR == 0) || (r_ptr == PTR_P0);

  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (!reset) begin
      if (w_elig0 && (!w_elig1 || w_p0_first)) begin
        w_grant0 = 1'b1;
      end else if (w_elig1) begin
        w_grant1 = 1'b1;
      end
    end
  end

  assign w_any_grant = w_grant0 || w_grant1;

  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_sel_op = '0;
    if (w_grant0) begin
      w_sel_a  = req0_a;
      w_sel_b  = req0_b;
      w_sel_op = req0_op;
    end else if (w_grant1) begin
      w_sel_a  = req1_a;
      w_sel_b  = req1_b;
      w_sel_op = req1_op;
    end
  end

  assign w_sel_illegal = (w_sel_op > OP_LAST_LEGAL);

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign alu_a      = w_sel_a;
  assign alu_b      = w_sel_b;
  assign alu_op     = w_sel_illegal ? 4'd0 : w_sel_op;

  // Illegal codes bypass the ALU result and load a fixed error response.
  assign w_ld_result = w_sel_illegal ? '0 : alu_result;
  assign w_ld_zero   = w_sel_illegal ? 1'b1 : alu_zero;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PTR_P0;
    end else if (w_any_grant) begin
      r_ptr <= w_grant0 ? PTR_P1 : PTR_P0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0_valid  <= 1'b0;
      r_rsp0_result <= '0;
      r_rsp0_zero   <= 1'b0;
      r_rsp0_err    <= 1'b0;
    end else if (w_grant0) begin
      r_rsp0_valid  <= 1'b1;
      r_rsp0_result <= w_ld_result;
      r_rsp0_zero   <= w_ld_zero;
      r_rsp0_err    <= w_sel_illegal;
    end else if (rsp0_ready) begin
      r_rsp0_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp1_valid  <= 1'b0;
      r_rsp1_result <= '0;
      r_rsp1_zero   <= 1'b0;
      r_rsp1_err    <= 1'b0;
    end else if (w_grant1) begin
      r_rsp1_valid  <= 1'b1;
      r_rsp1_result <= w_ld_result;
      r_rsp1_zero   <= w_ld_zero;
      r_rsp1_err    <= w_sel_illegal;
    end else if (rsp1_ready) begin
      r_rsp1_valid  <= 1'b0;
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_rsp0_result;
  assign rsp1_result = r_rsp1_result;
  assign rsp0_zero   = r_rsp0_zero;
  assign rsp1_zero   = r_rsp1_zero;
  assign rsp0_err    = r_rsp0_err;
  assign rsp1_err    = r_rsp1_err;

endmodule
